// File: rtl/proc_dpath_muldiv.sv
// Iterative 32-bit multiply/divide unit for the X stage: shift-add MUL and
// restoring DIV/DIVU/REM/REMU, fixed 32-iteration latency, val/rdy handshakes.
module proc_dpath_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [2:0]  req_fn,
    input  logic [31:0] req_op_a,
    input  logic [31:0] req_op_b,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_msg
);

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;
    localparam logic [5:0] ITERS   = 6'd32;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  cnt;

    logic [2:0]  fn;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic        ovf;
    logic [31:0] a_orig;
    logic [31:0] dsr;
    logic [31:0] dsr_next;
    logic [63:0] rq;
    logic [63:0] rq_next;
    logic [31:0] result;
    logic [31:0] result_next;

    logic        req_fire;
    logic        last_iter;
    logic        req_signed;
    logic        a_neg_in;
    logic        b_neg_in;

    logic [31:0] prod;
    logic [32:0] top;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] quot;
    logic [31:0] rem;

    function automatic logic [31:0] cond_neg(input logic signed [31:0] v, input logic en);
        logic signed [31:0] n;
        n = -v;
        return en ? n : v;
    endfunction

    assign req_fire   = req_val && req_rdy;
    assign last_iter  = (state == CALC) && (cnt == 6'd1);
    assign req_signed = (req_fn == FN_DIV) || (req_fn == FN_REM);
    assign a_neg_in   = req_signed && req_op_a[31];
    assign b_neg_in   = req_signed && req_op_b[31];
    assign resp_msg   = reset ? 32'd0 : result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_next;
            if (req_fire) begin
                cnt <= ITERS;
            end else if (state == CALC) begin
                cnt <= cnt - 6'd1;
            end
        end
    end

    // Handshake outputs depend only on state (and reset), never on req_val/resp_rdy.
    always_comb begin
        state_next = state;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) state_next = CALC;
            end
            CALC: begin
                if (cnt == 6'd1) state_next = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            req_rdy  = 1'b0;
            resp_val = 1'b0;
        end
    end

    // One iteration: MUL keeps {product, multiplier} in rq and shifts the
    // multiplicand in dsr; division keeps {remainder, dividend/quotient} in rq.
    always_comb begin
        prod     = rq[63:32];
        top      = rq[63:31];
        diff     = top - {1'b0, dsr};
        ge       = ~diff[32];
        rq_next  = rq;
        dsr_next = dsr;
        if (fn == FN_MUL) begin
            if (rq[0]) prod = rq[63:32] + dsr;
            rq_next  = {prod, 1'b0, rq[31:1]};
            dsr_next = {dsr[30:0], 1'b0};
        end else begin
            rq_next = {(ge ? diff[31:0] : top[31:0]), rq[30:0], ge};
        end
    end

    always_comb begin
        quot        = rq_next[31:0];
        rem         = rq_next[63:32];
        result_next = 32'd0;
        case (fn)
            FN_MUL:  result_next = rq_next[63:32];
            FN_DIV:  result_next = b_zero ? 32'hFFFF_FFFF :
                                   ovf    ? 32'h8000_0000 : cond_neg(quot, a_neg ^ b_neg);
            FN_DIVU: result_next = b_zero ? 32'hFFFF_FFFF : quot;
            FN_REM:  result_next = b_zero ? a_orig :
                                   ovf    ? 32'd0 : cond_neg(rem, a_neg);
            FN_REMU: result_next = b_zero ? a_orig : rem;
            default: result_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fn     <= 3'd0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            ovf    <= 1'b0;
            a_orig <= 32'd0;
            dsr    <= 32'd0;
            rq     <= 64'd0;
            result <= 32'd0;
        end else if (req_fire) begin
            fn     <= req_fn;
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            b_zero <= (req_op_b == 32'd0);
            ovf    <= req_signed && (req_op_a == 32'h8000_0000) && (req_op_b == 32'hFFFF_FFFF);
            a_orig <= req_op_a;
            if (req_fn == FN_MUL) begin
                rq  <= {32'd0, req_op_b};
                dsr <= req_op_a;
            end else begin
                rq  <= {32'd0, cond_neg(req_op_a, a_neg_in)};
                dsr <= cond_neg(req_op_b, b_neg_in);
            end
        end else if (state == CALC) begin
            rq  <= rq_next;
            dsr <= dsr_next;
            if (last_iter) result <= result_next;
        end
    end

endmodule

// File: doc/proc_dpath_muldiv.md
# proc_dpath_muldiv

Iterative multiply/divide unit for the processor's X stage, beside the single-cycle ALU. It takes two 32-bit operands from the same operand-bypass muxes that feed the ALU, computes one of MUL/DIV/DIVU/REM/REMU over a fixed number of cycles, and returns a 32-bit result to the X/M pipeline register. The control unit stalls X on `req_rdy`/`resp_val`, and the pipeline interacts with the block only through latency-insensitive val/rdy request and response interfaces.

## Interface
- No parameters. Width fixed at 32; iteration count fixed at 32.
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_val`  in  1  request valid
- `req_rdy`  out  1  unit can accept a request
- `req_fn`  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU, 5–7 reserved
- `req_op_a`  in  32  operand a: multiplicand or dividend
- `req_op_b`  in  32  operand b: multiplier or divisor
- `resp_val`  out  1  result valid
- `resp_rdy`  in  1  consumer accepts result
- `resp_msg`  out  32  result

## Operation
- **FSM states: IDLE, CALC, DONE.** Reset forces IDLE, clears the counter and clears all datapath registers.
- **IDLE**
  - `req_rdy`=1, `resp_val`=0.
  - On `req_val`&&`req_rdy`: latch fn, operands and the sign info; load counter=32; go to CALC.
- **CALC**
  - `req_rdy`=0, `resp_val`=0.
  - One iteration per cycle; counter decrements each cycle.
  - When the counter reaches 1, apply the final iteration and go to DONE.
- **DONE**
  - `resp_val`=1, `req_rdy`=0.
  - `resp_msg` holds the final value and is stable until the transfer.
  - On `resp_rdy`=1: go to IDLE.
  - No request is accepted in the same cycle as the response transfer.
- **MUL**
  - Shift-add over 32 iterations.
  - Result = low 32 bits of a×b. Signedness is irrelevant for the low word.
- **DIV / REM (signed)**
  - Restoring division on |a| and |b| using a 64-bit remainder/quotient register.
  - In DONE, negate the quotient if sign(a)≠sign(b).
  - The remainder takes the sign of a.
- **DIVU / REMU**
  - Same restoring datapath with no sign fixup.
- **Divisor zero**
  - DIV/DIVU → 0xFFFFFFFF.
  - REM/REMU → a.
- **Signed overflow (a=0x80000000, b=0xFFFFFFFF)**
  - DIV → 0x80000000.
  - REM → 0.
- **Reserved fn**
  - Result 0.
- **Latency is independent of operands.** Special cases are overridden in DONE and still take the full iteration count, so latency is fixed and the bench can predict it.
- **Reset mid-operation**
  - Any state → IDLE on the next edge; the in-flight result is discarded.
  - `resp_val` must never assert for the aborted request.

## Timing
- **Reset values**
  - While `reset`=1: `req_rdy`=0, `resp_val`=0, `resp_msg`=0.
  - First cycle after reset deasserts: `req_rdy`=1.
- **Latency**
  - A request fires in cycle T.
  - Cycles T+1..T+32 are CALC.
  - `resp_val`=1 from cycle T+33.
  - Response transfer no earlier than T+33.
  - Next request no earlier than T+34.
- **Backpressure**
  - `resp_rdy`=0 holds DONE indefinitely.
  - `resp_msg` and `resp_val` do not change while held.
- **Combinational paths**
  - `req_rdy` and `resp_val` are functions of state only.
  - There is no combinational path from `req_val` or `resp_rdy` to any output.
- **Request ports while busy**
  - `req_*` inputs are ignored whenever `req_rdy`=0.
  - Operands may change freely after the fire cycle.

## Test plan
- **Basic MUL:** reset 2 cycles, MUL a=7 b=6 with `resp_rdy`=1 → `resp_val` rises exactly 33 cycles after fire, `resp_msg`=42, and `req_rdy` returns to 1 the next cycle.
- **Signed arithmetic, back-to-back:** MUL 0xFFFFFFFD×5 → 0xFFFFFFF1; DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- **Corner cases:** DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each must show the same 33-cycle latency.
- **Backpressure:** DIVU 100/7 with `resp_rdy`=0 for 10 cycles after `resp_val` → `resp_msg`=14 held stable, `req_rdy`=0 throughout, a `req_val` pulse during the hold is not accepted; raise `resp_rdy` → transfer occurs, then IDLE.
- **Reset mid-operation:** fire MUL 3×3, assert `reset` at cycle T+10 for 1 cycle → `resp_val` stays 0; issue a new MUL 4×4 → result 16 after 33 cycles with no stale response.
- **Random regression:** 1000 random fn/operands with random `req_val`/`resp_rdy` gaps checked against a reference model → all results match, and no request is lost or duplicated.
